// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, function
// fields, ALU codes, immediate formats, instruction classes and FSM states.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] INST_R = 2'b00;
  localparam logic [1:0] INST_I = 2'b01;
  localparam logic [1:0] INST_S = 2'b10;
  localparam logic [1:0] INST_B = 2'b11;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } cls_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder. Illegal encodings drive all-zero
// controls so nothing downstream can act on them.
module control_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] im_data,
  output logic [3:0]  alu_op_o,
  output logic        alu_src_o,
  output logic [1:0]  inst_type_o,
  output logic        mem_to_reg_o,
  output cls_e        cls_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_bits;

  assign opcode = im_data[6:0];
  assign funct3 = im_data[14:12];
  assign funct7 = im_data[31:25];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_bits = ^{im_data[24:15], im_data[11:7]};

  // Decode opcode/funct fields into datapath controls and a class.
  always_comb begin
    alu_op_o     = ALU_AND;
    alu_src_o    = 1'b0;
    inst_type_o  = INST_R;
    mem_to_reg_o = 1'b0;
    cls_o        = CLS_ALU;
    illegal_o    = 1'b1;
    unique case (opcode)
      OP_R: begin
        alu_src_o   = 1'b1;
        inst_type_o = INST_R;
        if (funct3 == F3_ADD && funct7 == F7_BASE) begin
          alu_op_o = ALU_ADD; illegal_o = 1'b0;
        end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
          alu_op_o = ALU_SUB; illegal_o = 1'b0;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          alu_op_o = ALU_AND; illegal_o = 1'b0;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          alu_op_o = ALU_OR; illegal_o = 1'b0;
        end
      end
      OP_IMM: if (funct3 == F3_ADD) begin
        alu_op_o = ALU_ADD; inst_type_o = INST_I; illegal_o = 1'b0;
      end
      OP_LOAD: if (funct3 == F3_D) begin
        alu_op_o = ALU_ADD; inst_type_o = INST_I; mem_to_reg_o = 1'b1;
        cls_o = CLS_LOAD; illegal_o = 1'b0;
      end
      OP_STORE: if (funct3 == F3_D) begin
        alu_op_o = ALU_ADD; inst_type_o = INST_S;
        cls_o = CLS_STORE; illegal_o = 1'b0;
      end
      OP_BRANCH: if (funct3 == F3_BEQ) begin
        alu_op_o = ALU_SUB; alu_src_o = 1'b1; inst_type_o = INST_B;
        cls_o = CLS_BRANCH; illegal_o = 1'b0;
      end
      default: ;
    endcase
    if (illegal_o) begin
      alu_op_o     = ALU_AND;
      alu_src_o    = 1'b0;
      inst_type_o  = INST_R;
      mem_to_reg_o = 1'b0;
      cls_o        = CLS_ALU;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle controller: FETCH/EXEC/MEM/WB sequencing, PC register and
// retired-instruction counter. One architectural write per instruction.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int IM_L = 16,
  parameter int CW   = 32,
  localparam int PW  = $clog2(IM_L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   im_data,
  input  logic          ALUzero,
  input  logic [PW-1:0] PCnext,
  output logic [PW-1:0] PC,
  output logic          RegWrite,
  output logic          ALUsrc,
  output logic          PCsrc,
  output logic          MemtoReg,
  output logic [1:0]    instType,
  output logic [3:0]    ALUop,
  output logic          dm_we,
  output logic          dm_re,
  output logic          halted,
  output logic [CW-1:0] instret
);

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [CW-1:0] instret_q, instret_d;

  logic [3:0] dec_alu_op;
  logic       dec_alu_src;
  logic [1:0] dec_inst_type;
  logic       dec_mem_to_reg;
  cls_e       dec_cls;
  logic       dec_illegal;

  control_decoder u_dec (
    .im_data      (im_data),
    .alu_op_o     (dec_alu_op),
    .alu_src_o    (dec_alu_src),
    .inst_type_o  (dec_inst_type),
    .mem_to_reg_o (dec_mem_to_reg),
    .cls_o        (dec_cls),
    .illegal_o    (dec_illegal)
  );

  // State, PC and instret registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and control outputs; decoded controls held EXEC..WB only.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    RegWrite  = 1'b0;
    ALUsrc    = 1'b0;
    PCsrc     = 1'b0;
    MemtoReg  = 1'b0;
    instType  = INST_R;
    ALUop     = ALU_AND;
    dm_we     = 1'b0;
    dm_re     = 1'b0;
    halted    = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      ALUsrc   = dec_alu_src;
      MemtoReg = dec_mem_to_reg;
      instType = dec_inst_type;
      ALUop    = dec_alu_op;
    end
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_illegal) begin
          state_d = S_HALT;
        end else begin
          unique case (dec_cls)
            CLS_BRANCH: begin
              PCsrc     = ALUzero;
              pc_d      = PCnext;
              instret_d = instret_q + CW'(1);
              state_d   = S_FETCH;
            end
            CLS_LOAD, CLS_STORE: state_d = S_MEM;
            default:             state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (dec_cls == CLS_STORE) begin
          dm_we     = 1'b1;
          pc_d      = PCnext;
          instret_d = instret_q + CW'(1);
          state_d   = S_FETCH;
        end else begin
          dm_re   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        RegWrite  = 1'b1;
        pc_d      = PCnext;
        instret_d = instret_q + CW'(1);
        state_d   = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign PC      = pc_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks one program through
// ALU, branch, memory, wrap, illegal-halt and async-reset scenarios.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] im_data;
  logic        ALUzero;
  logic [3:0]  PCnext;
  logic [3:0]  PC;
  logic        RegWrite, ALUsrc, PCsrc, MemtoReg, dm_we, dm_re, halted;
  logic [1:0]  instType;
  logic [3:0]  ALUop;
  logic [31:0] instret;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ADDI = 32'h00508093;
  localparam logic [31:0] I_LD   = 32'h0000B183;
  localparam logic [31:0] I_SD   = 32'h0030B023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  multicycle_control_unit #(.IM_L(16), .CW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .im_data(im_data),
    .ALUzero(ALUzero), .PCnext(PCnext), .PC(PC), .RegWrite(RegWrite),
    .ALUsrc(ALUsrc), .PCsrc(PCsrc), .MemtoReg(MemtoReg), .instType(instType),
    .ALUop(ALUop), .dm_we(dm_we), .dm_re(dm_re), .halted(halted),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] im, input logic [3:0] pcn, input logic z);
    im_data = im; PCnext = pcn; ALUzero = z;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; issue(32'h0, 4'd0, 1'b0);
    #1;
    tests++; if ({PC, instret} !== 36'd0) begin fails++; $display("FAIL reset_pc_instret got PC=%0d instret=%0d want 0 0", PC, instret); end
    tests++; if ({RegWrite, PCsrc, dm_we, dm_re, halted} !== 5'b0) begin fails++; $display("FAIL reset_strobes got %b want 00000", {RegWrite, PCsrc, dm_we, dm_re, halted}); end
    #20 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if ({PC, RegWrite, ALUop} !== 9'd0) begin fails++; $display("FAIL idle_hold cyc%0d got PC=%0d RegWrite=%b ALUop=%b want 0", i, PC, RegWrite, ALUop); end
    end
  endtask

  task automatic test_alu();
    issue(I_ADD, 4'd1, 1'b0); start = 1'b1;
    step(); start = 1'b0;  // FETCH
    tests++; if ({RegWrite, ALUop, ALUsrc} !== 6'b0) begin fails++; $display("FAIL add_fetch got RegWrite=%b ALUop=%b ALUsrc=%b want 0", RegWrite, ALUop, ALUsrc); end
    step();  // EXEC
    tests++; if ({ALUop, ALUsrc, instType, RegWrite} !== {4'b0010, 1'b1, 2'b00, 1'b0}) begin fails++; $display("FAIL add_exec got ALUop=%b ALUsrc=%b instType=%b RegWrite=%b want 0010 1 00 0", ALUop, ALUsrc, instType, RegWrite); end
    step();  // WB
    tests++; if ({RegWrite, ALUop, PC} !== {1'b1, 4'b0010, 4'd0}) begin fails++; $display("FAIL add_wb got RegWrite=%b ALUop=%b PC=%0d want 1 0010 0", RegWrite, ALUop, PC); end
    step();  // FETCH
    tests++; if ({PC, instret, RegWrite} !== {4'd1, 32'd1, 1'b0}) begin fails++; $display("FAIL add_retire got PC=%0d instret=%0d RegWrite=%b want 1 1 0", PC, instret, RegWrite); end
    issue(I_SUB, 4'd2, 1'b0);
    step();
    tests++; if (ALUop !== 4'b0110) begin fails++; $display("FAIL sub_aluop got %b want 0110", ALUop); end
    step(); step();
    tests++; if ({PC, instret} !== {4'd2, 32'd2}) begin fails++; $display("FAIL sub_retire got PC=%0d instret=%0d want 2 2", PC, instret); end
    issue(I_AND, 4'd3, 1'b0);
    step();
    tests++; if ({ALUop, ALUsrc} !== {4'b0000, 1'b1}) begin fails++; $display("FAIL and_aluop got ALUop=%b ALUsrc=%b want 0000 1", ALUop, ALUsrc); end
    step(); step();
    tests++; if ({PC, instret} !== {4'd3, 32'd3}) begin fails++; $display("FAIL and_retire got PC=%0d instret=%0d want 3 3", PC, instret); end
  endtask

  task automatic test_branch();
    issue(I_BEQ, 4'd7, 1'b1);
    step();  // EXEC
    tests++; if ({PCsrc, ALUop, ALUsrc, instType, RegWrite} !== {1'b1, 4'b0110, 1'b1, 2'b11, 1'b0}) begin fails++; $display("FAIL beq_taken_exec got PCsrc=%b ALUop=%b ALUsrc=%b instType=%b RegWrite=%b want 1 0110 1 11 0", PCsrc, ALUop, ALUsrc, instType, RegWrite); end
    step();  // FETCH: 2-cycle instruction
    tests++; if ({PC, instret, PCsrc} !== {4'd7, 32'd4, 1'b0}) begin fails++; $display("FAIL beq_taken_retire got PC=%0d instret=%0d PCsrc=%b want 7 4 0", PC, instret, PCsrc); end
    issue(I_BEQ, 4'd4, 1'b0);
    step();
    tests++; if (PCsrc !== 1'b0) begin fails++; $display("FAIL beq_nt_pcsrc got %b want 0", PCsrc); end
    step();
    tests++; if ({PC, instret} !== {4'd4, 32'd5}) begin fails++; $display("FAIL beq_nt_retire got PC=%0d instret=%0d want 4 5", PC, instret); end
  endtask

  task automatic test_imm();
    issue(I_OR, 4'd5, 1'b0);
    step();
    tests++; if (ALUop !== 4'b0001) begin fails++; $display("FAIL or_aluop got %b want 0001", ALUop); end
    step(); step();
    issue(I_ADDI, 4'd6, 1'b0);
    step();
    tests++; if ({ALUop, ALUsrc, instType} !== {4'b0010, 1'b0, 2'b01}) begin fails++; $display("FAIL addi_exec got ALUop=%b ALUsrc=%b instType=%b want 0010 0 01", ALUop, ALUsrc, instType); end
    step();
    tests++; if (RegWrite !== 1'b1) begin fails++; $display("FAIL addi_wb got RegWrite=%b want 1", RegWrite); end
    step();
    tests++; if ({PC, instret} !== {4'd6, 32'd7}) begin fails++; $display("FAIL addi_retire got PC=%0d instret=%0d want 6 7", PC, instret); end
  endtask

  task automatic test_mem();
    issue(I_LD, 4'd7, 1'b0);
    step();  // EXEC
    tests++; if ({MemtoReg, dm_re, ALUop, instType} !== {1'b1, 1'b0, 4'b0010, 2'b01}) begin fails++; $display("FAIL ld_exec got MemtoReg=%b dm_re=%b ALUop=%b instType=%b want 1 0 0010 01", MemtoReg, dm_re, ALUop, instType); end
    step();  // MEM
    tests++; if ({dm_re, RegWrite, dm_we, PC} !== {1'b1, 1'b0, 1'b0, 4'd6}) begin fails++; $display("FAIL ld_mem got dm_re=%b RegWrite=%b dm_we=%b PC=%0d want 1 0 0 6", dm_re, RegWrite, dm_we, PC); end
    step();  // WB
    tests++; if ({RegWrite, MemtoReg, dm_re} !== 3'b110) begin fails++; $display("FAIL ld_wb got RegWrite=%b MemtoReg=%b dm_re=%b want 1 1 0", RegWrite, MemtoReg, dm_re); end
    step();
    tests++; if ({PC, instret} !== {4'd7, 32'd8}) begin fails++; $display("FAIL ld_retire got PC=%0d instret=%0d want 7 8", PC, instret); end
    issue(I_SD, 4'd8, 1'b0);
    step();  // EXEC
    tests++; if ({instType, dm_we, RegWrite} !== {2'b10, 1'b0, 1'b0}) begin fails++; $display("FAIL sd_exec got instType=%b dm_we=%b RegWrite=%b want 10 0 0", instType, dm_we, RegWrite); end
    step();  // MEM
    tests++; if ({dm_we, RegWrite, dm_re} !== 3'b100) begin fails++; $display("FAIL sd_mem got dm_we=%b RegWrite=%b dm_re=%b want 1 0 0", dm_we, RegWrite, dm_re); end
    step();  // FETCH
    tests++; if ({PC, instret, dm_we, RegWrite} !== {4'd8, 32'd9, 1'b0, 1'b0}) begin fails++; $display("FAIL sd_retire got PC=%0d instret=%0d dm_we=%b RegWrite=%b want 8 9 0 0", PC, instret, dm_we, RegWrite); end
  endtask

  task automatic test_wrap();
    issue(I_ADDI, 4'd15, 1'b0);
    step(); step(); step();
    tests++; if (PC !== 4'd15) begin fails++; $display("FAIL wrap_setup got PC=%0d want 15", PC); end
    issue(I_ADDI, 4'd0, 1'b0);
    step(); step(); step();
    tests++; if ({PC, instret} !== {4'd0, 32'd11}) begin fails++; $display("FAIL wrap_pc got PC=%0d instret=%0d want 0 11", PC, instret); end
  endtask

  task automatic test_illegal();
    issue(I_ECALL, 4'd9, 1'b1);
    step();  // EXEC
    tests++; if ({halted, RegWrite, PCsrc, dm_we, dm_re, ALUop} !== 9'd0) begin fails++; $display("FAIL ecall_exec got halted=%b strobes=%b ALUop=%b want 0", halted, {RegWrite, PCsrc, dm_we, dm_re}, ALUop); end
    step();  // HALT
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tests++; if ({halted, RegWrite, PCsrc, dm_we, dm_re, PC, instret} !== {1'b1, 4'b0, 4'd0, 32'd11}) begin fails++; $display("FAIL halt_hold cyc%0d got halted=%b strobes=%b PC=%0d instret=%0d want 1 0000 0 11", i, halted, {RegWrite, PCsrc, dm_we, dm_re}, PC, instret); end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_midwb();
    rst_n = 1'b0; #1 rst_n = 1'b1;
    issue(I_ADD, 4'd5, 1'b0); start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    tests++; if ({PC, instret, halted} !== {4'd5, 32'd1, 1'b0}) begin fails++; $display("FAIL post_halt_reset_add got PC=%0d instret=%0d halted=%b want 5 1 0", PC, instret, halted); end
    issue(I_ADD, 4'd6, 1'b0);
    step(); step();  // WB
    tests++; if (RegWrite !== 1'b1) begin fails++; $display("FAIL midwb_pre got RegWrite=%b want 1", RegWrite); end
    rst_n = 1'b0; #1;
    tests++; if ({PC, RegWrite, instret} !== {4'd0, 1'b0, 32'd0}) begin fails++; $display("FAIL midwb_async got PC=%0d RegWrite=%b instret=%0d want 0 0 0", PC, RegWrite, instret); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if ({PC, RegWrite, ALUop, instret} !== 41'd0) begin fails++; $display("FAIL midwb_idle cyc%0d got PC=%0d RegWrite=%b ALUop=%b instret=%0d want 0", i, PC, RegWrite, ALUop, instret); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_imm();
    test_mem();
    test_wrap();
    test_illegal();
    test_reset_midwb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle controller for the RV64 subset datapath (W=64, word-indexed instruction memory of IM_L words).
- Owns the PC register and decodes im_data.
- Sequences each instruction through FETCH/EXEC/MEM/WB so that only one register-file or data-memory write happens per instruction.
- Drives every datapath control input and counts retired instructions.

Parameters:
- IM_L, 16, instruction memory depth in words; PC width is PW = clog2(IM_L).
- CW, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE when high.
- im_data  in  32  current instruction (combinational read at PC).
- ALUzero  in  1  ALU zero flag from the datapath.
- PCnext  in  PW  next-PC value computed by the datapath.
- PC  out  PW  program counter register.
- RegWrite  out  1  register-file write enable.
- ALUsrc  out  1  ALU B select: 1 selects rs2, 0 selects the immediate.
- PCsrc  out  1  1 selects PC+imm in the datapath.
- MemtoReg  out  1  1 selects data-memory data for write-back.
- instType  out  2  immediate format: 00 R, 01 I, 10 S, 11 B.
- ALUop  out  4  ALU function: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- dm_we  out  1  data-memory write strobe.
- dm_re  out  1  data-memory read qualifier.
- halted  out  1  high in HALT.
- instret  out  CW  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; PC=0; instret=0.
  - All strobes (RegWrite, PCsrc, dm_we, dm_re, halted) are 0.
  - Reset mid-instruction aborts it; no write completes.
- Decode is combinational from im_data; PC is stable while an instruction executes.
  - R, opcode 0110011:
    - funct3 000, funct7 0000000: ADD
    - funct3 000, funct7 0100000: SUB
    - funct3 111, funct7 0000000: AND
    - funct3 110, funct7 0000000: OR
    - Settings: ALUsrc=1, instType=00.
  - addi, 0010011, funct3 000: ADD, ALUsrc=0, instType=01.
  - ld, 0000011, funct3 011: ADD, ALUsrc=0, instType=01, MemtoReg=1.
  - sd, 0100011, funct3 011: ADD, ALUsrc=0, instType=10.
  - beq, 1100011, funct3 000: SUB, ALUsrc=1, instType=11.
  - Any other encoding, including ecall 1110011, is illegal.
- ALUop, ALUsrc, instType and MemtoReg are held from EXEC through WB. In IDLE, FETCH and HALT they are all 0.
- States and transitions:
  - IDLE: waits; start=1 goes to FETCH.
  - FETCH: one settle cycle with no strobes; always goes to EXEC.
  - EXEC:
    - Illegal instruction: go to HALT; PC is unchanged.
    - beq: PCsrc=ALUzero; PC<=PCnext; instret++; go to FETCH.
    - ld or sd: go to MEM.
    - R or addi: go to WB.
  - MEM:
    - sd: dm_we=1 for this single cycle; PC<=PCnext (PCsrc=0); instret++; go to FETCH.
    - ld: dm_re=1; go to WB.
  - WB: RegWrite=1 for this single cycle; PC<=PCnext (PCsrc=0); instret++; go to FETCH.
  - HALT: halted=1; all strobes 0; start is ignored; the only exit is reset.
- Latency in cycles, FETCH included: beq 2; sd 3; R and addi 3; ld 4.
- PC wraps modulo IM_L because it is taken from PCnext truncated to PW bits. No overflow detection.
- instret wraps modulo 2^CW.
- At most one of RegWrite, dm_we or PC update is asserted per cycle, except the final PC update in the same cycle.
- start is sampled only in IDLE.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
  - funct3/funct7 constants
  - ALUop codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB
  - instType codes: INST_R, INST_I, INST_S, INST_B
  - state encoding: S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
- Sub-module control_decoder: purely combinational. Maps im_data to ALUop, ALUsrc, instType, MemtoReg, class (alu/load/store/branch) and illegal.
- The FSM, PC register and instret counter live in multicycle_control_unit.

Test Plan:
- Reset: rst_n=0 asserted mid-WB of an add → PC=0, RegWrite=0, state IDLE, instret=0 immediately (async). With start=0 for 5 cycles → PC stays 0.
- R-type: im_data=0x002081B3 (add x3,x1,x2), PC=0, PCnext=1 → EXEC drives ALUop=0010, ALUsrc=1. RegWrite=1 only in cycle 3 after FETCH. PC=1 and instret=1 after that edge.
- sub/and/or/addi: funct7=0100000 → ALUop=0110. funct3=111 → 0000. funct3=110 → 0001. addi 0x00508093 → ALUop=0010, ALUsrc=0, instType=01.
- Load/store: ld 0x0000B183 → dm_re in MEM, RegWrite+MemtoReg=1 in WB, 4 cycles. sd 0x0030B023 → dm_we=1 exactly 1 cycle, RegWrite never 1, instType=10.
- Branch: beq with ALUzero=1, PC=3, PCnext=7 → PCsrc=1 in EXEC, PC=7, 2 cycles. With ALUzero=0 and PCnext=4 → PCsrc=0, PC=4.
- Illegal/wrap: im_data=0x00000073 → HALT, halted=1, PC unchanged, no strobes for 10 cycles, start ignored. Also PC=15 with PCnext=0 (IM_L=16) → PC=0.
